// File: rtl/spi_pkg.sv
// SPI initiator shared types and sizing helpers.
// Also provides the `MAX macro used for port sizing.
`define MAX(a, b) ((a) > (b) ? (a) : (b))

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } state_t;

  function automatic int n_shifts(input int ww, input int sw);
    return ww / sw;
  endfunction

  // Edge counter must hold 2N+1 (HOLD expiry bumps it once more)
  function automatic int edge_w(input int ww, input int sw);
    return $clog2(2 * (ww / sw) + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI half-period timer and SCLK edge counter.
// Cleared by load; counts only while run is high.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int word_width = 8,
  parameter int send_width = 1,
  parameter int div_width  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   run,
  input  logic [div_width-1:0]   div,
  output logic                   tick,
  output logic [edge_w(word_width, send_width)-1:0] k_idx,
  output logic                   last
);

  localparam int KW = edge_w(word_width, send_width);
  localparam int NE = 2 * n_shifts(word_width, send_width);

  logic [div_width-1:0] cnt_q;
  logic [KW-1:0]        k_q;

  assign tick  = run && (cnt_q == div);
  assign k_idx = k_q + 1'b1;
  assign last  = tick && (k_idx == KW'(NE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      k_q   <= '0;
    end else if (load) begin
      cnt_q <= '0;
      k_q   <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      k_q   <= k_idx;
    end else if (run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tree_decoder.sv
// Enabled binary-to-one-hot decoder.
// Indices with no matching output decode to all zeros.
module tree_decoder #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4
) (
  input  logic             en,
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] dec
);

  always_comb begin
    dec = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dec[i] = en && (sel == IN_W'(i));
    end
  end

endmodule

// File: rtl/spi_master.sv
// Clocked SPI initiator: start/ready in, rx_valid out.
// Mode, divider and slave index are frozen per word.
module spi_master
  import spi_pkg::*;
#(
  parameter int word_width = 8,
  parameter int send_width = 1,
  parameter int SS_width   = 1,
  parameter int div_width  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cpol,
  input  logic                                 cpha,
  input  logic [div_width-1:0]                 clk_div,
  input  logic [$clog2(`MAX(SS_width, 2))-1:0] ss_sel,
  input  logic                                 start,
  input  logic [word_width-1:0]                tx_data,
  output logic                                 ready,
  output logic [word_width-1:0]                rx_data,
  output logic                                 rx_valid,
  output logic                                 SCLK,
  output logic [send_width-1:0]                SD_OUT,
  input  logic [send_width-1:0]                SD_IN,
  output logic [SS_width-1:0]                  SS_OUT
);

  localparam int KW = edge_w(word_width, send_width);
  localparam int SW = $clog2(`MAX(SS_width, 2));

  if (word_width % send_width != 0) begin : g_chk
    $error("word_width must be a multiple of send_width");
  end

  state_t state_q, state_d;

  logic                  go, tick, last, hold_done;
  logic                  odd, smp, shf;
  logic [KW-1:0]         k_idx;
  logic [word_width-1:0] shreg, rx_sh, rx_nxt;
  logic                  cpol_q, cpha_q;
  logic [div_width-1:0]  div_q;
  logic [SW-1:0]         sel_q, sel_d;
  logic [SS_width-1:0]   dec;

  assign go        = start && ready;
  assign hold_done = (state_q == HOLD) && tick;
  assign SD_OUT    = shreg[word_width-1 -: send_width];
  assign rx_nxt    = (rx_sh << send_width) | word_width'(SD_IN);
  assign sel_d     = go ? ss_sel : sel_q;

  spi_clk_gen #(
    .word_width(word_width),
    .send_width(send_width),
    .div_width (div_width)
  ) u_clk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .load (go),
    .run  (state_q != IDLE),
    .div  (div_q),
    .tick (tick),
    .k_idx(k_idx),
    .last (last)
  );

  tree_decoder #(
    .IN_W (SW),
    .OUT_W(SS_width)
  ) u_ss_dec (
    .en (state_d != IDLE),
    .sel(sel_d),
    .dec(dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go)   state_d = ACTIVE;
      ACTIVE:  if (last) state_d = HOLD;
      HOLD:    if (tick) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // cpha=0: sample odd edges; cpha=1: sample even edges
  always_comb begin
    odd = k_idx[0];
    smp = 1'b0;
    shf = 1'b0;
    if (state_q == ACTIVE && tick) begin
      smp = cpha_q ? !odd : odd;
      shf = cpha_q ? (odd && k_idx != KW'(1)) : (!odd && !last);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      SCLK     <= 1'b0;
      SS_OUT   <= '0;
      shreg    <= '0;
      rx_sh    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      sel_q    <= '0;
    end else begin
      ready    <= (state_d == IDLE);
      rx_valid <= 1'b0;
      SS_OUT   <= dec;
      if (state_q == IDLE) SCLK <= cpol;
      else if (state_q == ACTIVE && tick) SCLK <= ~SCLK;
      else if (hold_done) SCLK <= cpol_q;
      if (go) begin
        shreg  <= tx_data;
        rx_sh  <= '0;
        cpol_q <= cpol;
        cpha_q <= cpha;
        div_q  <= clk_div;
        sel_q  <= ss_sel;
      end
      if (shf) shreg <= shreg << send_width;
      if (smp) rx_sh <= rx_nxt;
      if (hold_done) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule
